ysyx_23060221_axi_rr_arbiter: RTL and testbench
===============================================

// Module: ysyx_23060221_axi_rr_arbiter
// PURPOSE
//  Two-master, one-slave AXI4 arbiter placed between the core bus masters (M0=IFU, M1=LSU) and the
//  downstream crossbar/io_master. Round-robin grant, registered. A grant is held for one whole
//  transaction (read: AR + all R beats; write: AW + all W beats + B). Only one transaction is in flight.
// PARAMETERS
//  AW      32  address width
//  DW      32  data width (strobe width DW/8)
//  IDW     4   ID width
// PORTS
//  clk                                     in   1      clock, all logic on rising edge
//  rst                                     in   1      synchronous reset, active-high
//  m{0,1}_ar{valid,addr,id,len,size,burst} in   1/AW/IDW/8/3/2  master read-address channel
//  m{0,1}_arready                          out  1      read-address accept
//  m{0,1}_r{valid,resp,data,last,id}       out  1/2/DW/1/IDW    read-data channel to master
//  m{0,1}_rready                           in   1      master read-data accept
//  m{0,1}_aw{valid,addr,id,len,size,burst} in   1/AW/IDW/8/3/2  master write-address channel
//  m{0,1}_awready                          out  1      write-address accept
//  m{0,1}_w{valid,data,strb,last}          in   1/DW/DW/8/1     master write-data channel
//  m{0,1}_wready                           out  1      write-data accept
//  m{0,1}_b{valid,resp,id}                 out  1/2/IDW         write response to master
//  m{0,1}_bready                           in   1      master response accept
//  s_*                                     mirror  -   same five channels toward slave, directions reversed
//  last_err                                out  1      1-cycle pulse: R/W beat count disagrees with *len at last
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=M1 (so M0 wins first contest), beat counter=0. All valid/ready
//    outputs 0, all payload outputs 0, last_err=0. Reset mid-transaction abandons it; bench reissues.
//  - States: IDLE, RD_A, RD_D, WR_AD, WR_B. Grant register g in {M0,M1}, valid outside IDLE.
//  - IDLE: req_m = m_arvalid|m_awvalid. One requester -> grant it. Both -> grant !last_grant.
//    Per master, arvalid wins over awvalid (-> RD_A, else -> WR_AD). last_grant<=g. The grant
//    decision is registered: downstream valid asserts 1 cycle after the request is seen.
//  - Only the granted master is connected. Non-granted master sees all ready/valid=0, payload=0.
//  - RD_A: s_ar* = g's ar*. On s_arvalid&s_arready latch arlen, beat=0 -> RD_D.
//    s_arvalid is forced 0 after the handshake.
//  - RD_D: s_r* -> g's r*; s_rready=g_rready. Each R handshake beat++. R handshake with rlast -> IDLE.
//    If beat!=latched len at that handshake, last_err pulses. Beats past len stay passed through.
//  - WR_AD: AW and W forwarded concurrently; W may handshake before AW (AXI-legal).
//    Flags aw_done/w_done; w_done is set on a W handshake with wlast. s_awvalid is forced 0 after
//    aw_done. s_wvalid is forced 0 after w_done. W-beat count checked against awlen at wlast (last_err).
//    Both flags set -> WR_B.
//  - WR_B: s_b* -> g's b*; B handshake -> IDLE.
//  - A new request arriving mid-transaction waits. Valid held high by master per AXI.
//    The next arbitration happens in the IDLE cycle after the done cycle, so 1 idle bubble per switch.
//  - The beat counter is 9 bits, saturating at 256. It is never wrapped.
//  - Same-cycle done and new request: done wins; the request is evaluated in the following IDLE cycle.
// CONFIGURATION
//  - ARB_PERF_EN defined: adds outputs perf_grant0, perf_grant1, perf_wait (each 32 bit).
//      perf_grant0 / perf_grant1: +1 per grant to M0 / M1.
//      perf_wait: +1 per cycle a master has valid pending while not granted.
//      All three wrap at 2^32 and clear on rst.
//  - ARB_PERF_EN undefined: the ports and counters are absent; arbitration behaviour is identical.
// TESTING
//  1 Reset, M0 ar addr=0x8000_0000 len=0 -> s_arvalid at cycle 2, R data 0x1234 rlast -> m0_rdata=0x1234, IDLE next cycle.
//  2 M0 ar and M1 ar same cycle, 3 rounds -> grant order M0,M1,M0,M1,M0,M1; no overlap on s_*.
//  3 M1 aw len=3 with W leading AW by 2 cycles, 4 beats strb=0xF -> 4 s_w handshakes, 1 B to M1, last_err=0.
//  4 M0 ar len=3, slave sends rlast on beat 2 -> last_err pulses once, grant released.
//  5 rst asserted in RD_D mid-burst -> next cycle all outputs 0, state IDLE, M0 wins next contest.
//  6 ARB_PERF_EN: scenario 2 -> perf_grant0=3, perf_grant1=3, perf_wait>0; all 0 after rst.

Source files
------------

// File: rtl/ysyx_23060221_axi_rr_arbiter_if.sv
// AXI4 five-channel bundle shared by the arbiter's master-facing and slave-facing ports.
//   master modport: the side that issues AR/AW/W and accepts R/B (a bus master, or the
//                   arbiter's downstream port).
//   slave modport : the side that accepts AR/AW/W and returns R/B.
// Parameters: AW address width, DW data width (strobe DW/8), IDW ID width.
interface ysyx_23060221_axi_rr_arbiter_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned IDW = 4
);
    logic              arvalid, arready;
    logic [AW-1:0]     araddr;
    logic [IDW-1:0]    arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid, rready, rlast;
    logic [1:0]        rresp;
    logic [DW-1:0]     rdata;
    logic [IDW-1:0]    rid;

    logic              awvalid, awready;
    logic [AW-1:0]     awaddr;
    logic [IDW-1:0]    awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid, wready, wlast;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;

    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic [IDW-1:0]    bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
               awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rresp, rdata, rlast, rid, awready, wready,
               bvalid, bresp, bid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
               awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rresp, rdata, rlast, rid, awready, wready,
               bvalid, bresp, bid
    );
endinterface

// File: rtl/ysyx_23060221_axi_rr_arbiter.sv
// Two-master / one-slave AXI4 round-robin arbiter (M0 = IFU, M1 = LSU).
// One transaction in flight; the grant is registered and held for a whole read
// (AR + all R) or write (AW + all W + B). The granted master is passed straight
// through; the other master sees all ready/valid/payload at 0.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   m0, m1      master-facing AXI ports (slave modport)
//   s           downstream AXI port (master modport)
//   last_err    1-cycle pulse when an R/W burst's beat count disagrees with its len
// Optional build macro ARB_PERF_EN adds perf_grant0, perf_grant1, perf_wait (32-bit, wrapping).
module ysyx_23060221_axi_rr_arbiter #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned IDW = 4
) (
    input  logic clk,
    input  logic rst,
    ysyx_23060221_axi_rr_arbiter_if.slave  m0,
    ysyx_23060221_axi_rr_arbiter_if.slave  m1,
    ysyx_23060221_axi_rr_arbiter_if.master s,
    output logic last_err
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] perf_grant0,
    output logic [31:0] perf_grant1,
    output logic [31:0] perf_wait
`endif
);
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned BEAT_W = 9;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(256);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_A  = 3'd1;
    localparam logic [2:0] RD_D  = 3'd2;
    localparam logic [2:0] WR_AD = 3'd3;
    localparam logic [2:0] WR_B  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              grant_q, last_grant_q;
    logic [BEAT_W-1:0] beat_q;
    logic [7:0]        len_q;
    logic              aw_done_q, w_done_q;

    // Request-side signals of the currently granted master
    logic              g_arvalid, g_rready, g_awvalid, g_wvalid, g_wlast, g_bready;
    logic [AW-1:0]     g_araddr, g_awaddr;
    logic [IDW-1:0]    g_arid, g_awid;
    logic [7:0]        g_arlen, g_awlen;
    logic [2:0]        g_arsize, g_awsize;
    logic [1:0]        g_arburst, g_awburst;
    logic [DW-1:0]     g_wdata;
    logic [SW-1:0]     g_wstrb;

    // Response-side signals destined for the granted master
    logic              g_arready, g_rvalid, g_rlast, g_awready, g_wready, g_bvalid;
    logic [1:0]        g_rresp, g_bresp;
    logic [DW-1:0]     g_rdata;
    logic [IDW-1:0]    g_rid, g_bid;

    logic req0, req1, req_any, pick, pick_rd;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, w_last_hs;
    logic [7:0] wlen;

    assign g_arvalid = grant_q ? m1.arvalid : m0.arvalid;
    assign g_araddr  = grant_q ? m1.araddr  : m0.araddr;
    assign g_arid    = grant_q ? m1.arid    : m0.arid;
    assign g_arlen   = grant_q ? m1.arlen   : m0.arlen;
    assign g_arsize  = grant_q ? m1.arsize  : m0.arsize;
    assign g_arburst = grant_q ? m1.arburst : m0.arburst;
    assign g_rready  = grant_q ? m1.rready  : m0.rready;
    assign g_awvalid = grant_q ? m1.awvalid : m0.awvalid;
    assign g_awaddr  = grant_q ? m1.awaddr  : m0.awaddr;
    assign g_awid    = grant_q ? m1.awid    : m0.awid;
    assign g_awlen   = grant_q ? m1.awlen   : m0.awlen;
    assign g_awsize  = grant_q ? m1.awsize  : m0.awsize;
    assign g_awburst = grant_q ? m1.awburst : m0.awburst;
    assign g_wvalid  = grant_q ? m1.wvalid  : m0.wvalid;
    assign g_wdata   = grant_q ? m1.wdata   : m0.wdata;
    assign g_wstrb   = grant_q ? m1.wstrb   : m0.wstrb;
    assign g_wlast   = grant_q ? m1.wlast   : m0.wlast;
    assign g_bready  = grant_q ? m1.bready  : m0.bready;

    assign m0.arready = ~grant_q & g_arready;
    assign m1.arready =  grant_q & g_arready;
    assign m0.rvalid  = ~grant_q & g_rvalid;
    assign m1.rvalid  =  grant_q & g_rvalid;
    assign m0.rlast   = ~grant_q & g_rlast;
    assign m1.rlast   =  grant_q & g_rlast;
    assign m0.rresp   = grant_q ? '0 : g_rresp;
    assign m1.rresp   = grant_q ? g_rresp : '0;
    assign m0.rdata   = grant_q ? '0 : g_rdata;
    assign m1.rdata   = grant_q ? g_rdata : '0;
    assign m0.rid     = grant_q ? '0 : g_rid;
    assign m1.rid     = grant_q ? g_rid : '0;
    assign m0.awready = ~grant_q & g_awready;
    assign m1.awready =  grant_q & g_awready;
    assign m0.wready  = ~grant_q & g_wready;
    assign m1.wready  =  grant_q & g_wready;
    assign m0.bvalid  = ~grant_q & g_bvalid;
    assign m1.bvalid  =  grant_q & g_bvalid;
    assign m0.bresp   = grant_q ? '0 : g_bresp;
    assign m1.bresp   = grant_q ? g_bresp : '0;
    assign m0.bid     = grant_q ? '0 : g_bid;
    assign m1.bid     = grant_q ? g_bid : '0;

    // Round-robin pick: a lone requester wins, a tie goes to the master not granted last
    assign req0    = m0.arvalid | m0.awvalid;
    assign req1    = m1.arvalid | m1.awvalid;
    assign req_any = req0 | req1;
    assign pick    = (req0 & req1) ? ~last_grant_q : req1;
    assign pick_rd = pick ? m1.arvalid : m0.arvalid;

    // Handshakes as seen on the downstream port; the done flags mask repeated AW/W
    assign ar_hs     = (state_q == RD_A)  & g_arvalid & s.arready;
    assign r_hs      = (state_q == RD_D)  & s.rvalid & g_rready;
    assign aw_hs     = (state_q == WR_AD) & ~aw_done_q & g_awvalid & s.awready;
    assign w_hs      = (state_q == WR_AD) & ~w_done_q & g_wvalid & s.wready;
    assign w_last_hs = w_hs & g_wlast;
    assign b_hs      = (state_q == WR_B)  & s.bvalid & g_bready;

    // W may finish before AW: until AW is accepted the master is still holding awlen
    assign wlen = aw_done_q ? len_q : g_awlen;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and channel routing
    always_comb begin
        state_d   = state_q;
        s.arvalid = 1'b0; s.araddr = '0; s.arid = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0;
        s.rready  = 1'b0;
        s.awvalid = 1'b0; s.awaddr = '0; s.awid = '0; s.awlen = '0; s.awsize = '0; s.awburst = '0;
        s.wvalid  = 1'b0; s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0;
        s.bready  = 1'b0;
        g_arready = 1'b0;
        g_rvalid  = 1'b0; g_rresp = '0; g_rdata = '0; g_rlast = 1'b0; g_rid = '0;
        g_awready = 1'b0; g_wready = 1'b0;
        g_bvalid  = 1'b0; g_bresp = '0; g_bid = '0;
        case (state_q)
            IDLE: begin
                if (req_any) state_d = pick_rd ? RD_A : WR_AD;
            end
            RD_A: begin
                s.arvalid = g_arvalid; s.araddr = g_araddr; s.arid = g_arid;
                s.arlen = g_arlen; s.arsize = g_arsize; s.arburst = g_arburst;
                g_arready = s.arready;
                if (ar_hs) state_d = RD_D;
            end
            RD_D: begin
                s.rready = g_rready;
                g_rvalid = s.rvalid; g_rresp = s.rresp; g_rdata = s.rdata;
                g_rlast  = s.rlast;  g_rid   = s.rid;
                if (r_hs && s.rlast) state_d = IDLE;
            end
            WR_AD: begin
                if (!aw_done_q) begin
                    s.awvalid = g_awvalid; s.awaddr = g_awaddr; s.awid = g_awid;
                    s.awlen = g_awlen; s.awsize = g_awsize; s.awburst = g_awburst;
                    g_awready = s.awready;
                end
                if (!w_done_q) begin
                    s.wvalid = g_wvalid; s.wdata = g_wdata; s.wstrb = g_wstrb; s.wlast = g_wlast;
                    g_wready = s.wready;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) state_d = WR_B;
            end
            WR_B: begin
                s.bready = g_bready;
                g_bvalid = s.bvalid; g_bresp = s.bresp; g_bid = s.bid;
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant, burst bookkeeping and length check
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            len_q        <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            last_err     <= 1'b0;
        end else begin
            last_err <= (r_hs & s.rlast & (beat_q != BEAT_W'(len_q)))
                      | (w_last_hs & (beat_q != BEAT_W'(wlen)));
            if (state_q == IDLE) begin
                beat_q    <= '0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                if (req_any) begin
                    grant_q      <= pick;
                    last_grant_q <= pick;
                end
            end
            if (ar_hs) begin
                len_q  <= g_arlen;
                beat_q <= '0;
            end
            if (aw_hs) begin
                len_q     <= g_awlen;
                aw_done_q <= 1'b1;
            end
            if (w_last_hs) w_done_q <= 1'b1;
            // Counter saturates at 256 rather than wrapping
            if (r_hs || w_hs) beat_q <= beat_q + BEAT_W'(beat_q != BEAT_MAX);
        end
    end

`ifdef ARB_PERF_EN
    logic busy, wait_any;
    assign busy     = (state_q != IDLE);
    assign wait_any = (req0 & ~(busy & ~grant_q)) | (req1 & ~(busy & grant_q));

    // Grant and wait-cycle counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_wait   <= '0;
        end else begin
            if (state_q == IDLE && req_any && !pick) perf_grant0 <= perf_grant0 + 32'd1;
            if (state_q == IDLE && req_any &&  pick) perf_grant1 <= perf_grant1 + 32'd1;
            if (wait_any) perf_wait <= perf_wait + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_23060221_axi_rr_arbiter.sv
// Directed bench for the two-master AXI round-robin arbiter.
module tb_ysyx_23060221_axi_rr_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned IDW = 4;

    logic clk;
    logic rst;
    logic last_err;
`ifdef ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_wait;
`endif

    int n_checks;
    int n_fail;
    int err_pulses;

    ysyx_23060221_axi_rr_arbiter_if #(.AW(AW), .DW(DW), .IDW(IDW)) m0_if ();
    ysyx_23060221_axi_rr_arbiter_if #(.AW(AW), .DW(DW), .IDW(IDW)) m1_if ();
    ysyx_23060221_axi_rr_arbiter_if #(.AW(AW), .DW(DW), .IDW(IDW)) s_if ();

    ysyx_23060221_axi_rr_arbiter #(.AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if.slave),
        .m1       (m1_if.slave),
        .s        (s_if.master),
        .last_err (last_err)
`ifdef ARB_PERF_EN
        ,
        .perf_grant0 (perf_grant0),
        .perf_grant1 (perf_grant1),
        .perf_wait   (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (last_err === 1'b1) err_pulses = err_pulses + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ar(input int m, input logic v, input logic [AW-1:0] addr,
                          input logic [IDW-1:0] id, input logic [7:0] len);
        if (m == 0) begin
            m0_if.arvalid = v; m0_if.araddr = addr; m0_if.arid = id; m0_if.arlen = len;
        end else begin
            m1_if.arvalid = v; m1_if.araddr = addr; m1_if.arid = id; m1_if.arlen = len;
        end
    endtask

    task automatic init_signals();
        m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.arid = '0; m0_if.arlen = '0;
        m0_if.arsize = 3'd2; m0_if.arburst = 2'd1; m0_if.rready = 1;
        m0_if.awvalid = 0; m0_if.awaddr = '0; m0_if.awid = '0; m0_if.awlen = '0;
        m0_if.awsize = 3'd2; m0_if.awburst = 2'd1;
        m0_if.wvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wlast = 0; m0_if.bready = 1;
        m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.arid = '0; m1_if.arlen = '0;
        m1_if.arsize = 3'd2; m1_if.arburst = 2'd1; m1_if.rready = 1;
        m1_if.awvalid = 0; m1_if.awaddr = '0; m1_if.awid = '0; m1_if.awlen = '0;
        m1_if.awsize = 3'd2; m1_if.awburst = 2'd1;
        m1_if.wvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wlast = 0; m1_if.bready = 1;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rresp = '0; s_if.rdata = '0; s_if.rlast = 0;
        s_if.rid = '0; s_if.awready = 0; s_if.wready = 0;
        s_if.bvalid = 0; s_if.bresp = '0; s_if.bid = '0;
    endtask

    // Slave side of one read: accept AR, return nbeats R beats (rlast on the final one).
    // M0 always issues ID 1 and M1 ID 2.
    task automatic slave_read(input int nbeats, input logic [DW-1:0] dbase, output int who);
        int n;
        logic [IDW-1:0] exp_id;
        n = 0;
        settle();
        while (s_if.arvalid !== 1'b1 && n < 20) begin
            tick();
            settle();
            n++;
        end
        check("ar_wait", 64'(n < 20), 64'(1));
        s_if.arready = 1'b1;
        settle();
        who = (m1_if.arready === 1'b1) ? 1 : 0;
        exp_id = (who == 1) ? IDW'(2) : IDW'(1);
        check("ar_one_ready", 64'(m0_if.arready ^ m1_if.arready), 64'(1));
        check("ar_id", 64'(s_if.arid), 64'(exp_id));
        tick();
        s_if.arready = 1'b0;
        set_ar(who, 1'b0, '0, '0, '0);
        for (int i = 0; i < nbeats; i++) begin
            s_if.rvalid = 1'b1;
            s_if.rdata  = dbase + DW'(i);
            s_if.rlast  = (i == nbeats - 1);
            s_if.rid    = exp_id;
            settle();
            check("r_data", 64'((who == 1) ? m1_if.rdata : m0_if.rdata), 64'(dbase + DW'(i)));
            check("r_id", 64'((who == 1) ? m1_if.rid : m0_if.rid), 64'(exp_id));
            check("r_other_quiet", 64'((who == 1) ? m0_if.rvalid : m1_if.rvalid), 64'(0));
            tick();
        end
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int who;
        int n;
        int nw;
        int e0;
        int left0;
        int left1;
        n_checks   = 0;
        n_fail     = 0;
        err_pulses = 0;
        rst        = 1'b1;
        init_signals();

        // 1: reset state, then single-beat M0 read
        do_reset();
        settle();
        check("rst_s_arvalid", 64'(s_if.arvalid), 64'(0));
        check("rst_s_awvalid", 64'(s_if.awvalid), 64'(0));
        check("rst_s_wvalid", 64'(s_if.wvalid), 64'(0));
        check("rst_m0_arready", 64'(m0_if.arready), 64'(0));
        check("rst_m1_rvalid", 64'(m1_if.rvalid), 64'(0));
        check("rst_s_araddr", 64'(s_if.araddr), 64'(0));
        check("rst_last_err", 64'(last_err), 64'(0));
        set_ar(0, 1'b1, 32'h8000_0000, 4'd1, 8'd0);
        settle();
        check("ar_cycle1_quiet", 64'(s_if.arvalid), 64'(0));
        tick();
        settle();
        check("ar_cycle2_valid", 64'(s_if.arvalid), 64'(1));
        check("ar_cycle2_addr", 64'(s_if.araddr), 64'h8000_0000);
        slave_read(1, 32'h0000_1234, who);
        check("t1_grant", 64'(who), 64'(0));
        settle();
        check("t1_idle_rvalid", 64'(m0_if.rvalid), 64'(0));
        check("t1_idle_rready", 64'(s_if.rready), 64'(0));
        check("t1_last_err", 64'(last_err), 64'(0));

        // 2: both masters contend for three rounds each
        do_reset();
        settle();
`ifdef ARB_PERF_EN
        check("perf_g0_rst", 64'(perf_grant0), 64'(0));
        check("perf_g1_rst", 64'(perf_grant1), 64'(0));
        check("perf_wait_rst", 64'(perf_wait), 64'(0));
`endif
        left0 = 3;
        left1 = 3;
        set_ar(0, 1'b1, 32'h8000_0010, 4'd1, 8'd0);
        set_ar(1, 1'b1, 32'h8000_0020, 4'd2, 8'd0);
        for (int r = 0; r < 6; r++) begin
            slave_read(1, 32'hA000_0000 + DW'(r), who);
            check("rr_order", 64'(who), 64'(r % 2));
            if (who == 0) begin
                left0--;
                if (left0 > 0) set_ar(0, 1'b1, 32'h8000_0010, 4'd1, 8'd0);
            end else begin
                left1--;
                if (left1 > 0) set_ar(1, 1'b1, 32'h8000_0020, 4'd2, 8'd0);
            end
        end
`ifdef ARB_PERF_EN
        check("perf_g0", 64'(perf_grant0), 64'(3));
        check("perf_g1", 64'(perf_grant1), 64'(3));
        check("perf_wait_nz", 64'(perf_wait != 32'd0), 64'(1));
`endif

        // 3: M1 write, len=3, two W beats accepted before AW
        e0 = err_pulses;
        m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h9000_0000; m1_if.awid = 4'd3; m1_if.awlen = 8'd3;
        m1_if.wvalid = 1'b1; m1_if.wdata = 32'hD000_0000; m1_if.wstrb = 4'hF; m1_if.wlast = 1'b0;
        s_if.wready = 1'b1;
        s_if.awready = 1'b0;
        n = 0;
        settle();
        while (s_if.wvalid !== 1'b1 && n < 20) begin
            tick();
            settle();
            n++;
        end
        check("w_wait", 64'(n < 20), 64'(1));
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) s_if.awready = 1'b1;
            settle();
            check("w_data", 64'(s_if.wdata), 64'(32'hD000_0000 + DW'(i)));
            check("w_strb", 64'(s_if.wstrb), 64'(4'hF));
            if (s_if.wvalid === 1'b1 && m1_if.wready === 1'b1) nw++;
            if (i < 2) check("aw_held", 64'(m1_if.awready), 64'(0));
            if (i == 2) check("aw_hs", 64'({s_if.awvalid, m1_if.awready}), 64'(2'b11));
            if (i == 3) check("aw_dropped", 64'(s_if.awvalid), 64'(0));
            tick();
            if (i == 2) begin
                s_if.awready = 1'b0;
                m1_if.awvalid = 1'b0;
            end
            m1_if.wdata = 32'hD000_0000 + DW'(i + 1);
            m1_if.wlast = (i + 1 == 3);
        end
        m1_if.wvalid = 1'b0;
        m1_if.wlast  = 1'b0;
        s_if.wready  = 1'b0;
        check("w_count", 64'(nw), 64'(4));
        s_if.bvalid = 1'b1;
        s_if.bid    = 4'd3;
        settle();
        check("w_dropped", 64'(s_if.wvalid), 64'(0));
        check("b_m1_valid", 64'(m1_if.bvalid), 64'(1));
        check("b_m1_id", 64'(m1_if.bid), 64'(3));
        check("b_m0_quiet", 64'(m0_if.bvalid), 64'(0));
        check("b_bready", 64'(s_if.bready), 64'(1));
        check("w_last_err", 64'(last_err), 64'(0));
        tick();
        s_if.bvalid = 1'b0;
        s_if.bid    = '0;
        settle();
        check("b_done", 64'(m1_if.bvalid), 64'(0));
        check("w_err_pulses", 64'(err_pulses - e0), 64'(0));

        // 4: M0 read len=3 but rlast on the third beat
        e0 = err_pulses;
        set_ar(0, 1'b1, 32'h8000_0100, 4'd1, 8'd3);
        slave_read(3, 32'hB000_0000, who);
        check("t4_grant", 64'(who), 64'(0));
        settle();
        check("t4_err_high", 64'(last_err), 64'(1));
        tick();
        settle();
        check("t4_err_low", 64'(last_err), 64'(0));
        check("t4_err_pulses", 64'(err_pulses - e0), 64'(1));
        set_ar(1, 1'b1, 32'h8000_0200, 4'd2, 8'd0);
        slave_read(1, 32'hC000_0000, who);
        check("t4_released", 64'(who), 64'(1));

        // 5: reset in the middle of a read burst
        set_ar(0, 1'b1, 32'h8000_0300, 4'd1, 8'd3);
        n = 0;
        settle();
        while (s_if.arvalid !== 1'b1 && n < 20) begin
            tick();
            settle();
            n++;
        end
        check("t5_ar_wait", 64'(n < 20), 64'(1));
        s_if.arready = 1'b1;
        tick();
        s_if.arready = 1'b0;
        set_ar(0, 1'b0, '0, '0, '0);
        s_if.rvalid = 1'b1;
        s_if.rdata  = 32'h0000_0055;
        s_if.rid    = 4'd1;
        settle();
        check("t5_beat0", 64'(m0_if.rvalid), 64'(1));
        tick();
        rst = 1'b1;
        tick();
        settle();
        check("t5_rst_rvalid", 64'(m0_if.rvalid), 64'(0));
        check("t5_rst_rdata", 64'(m0_if.rdata), 64'(0));
        check("t5_rst_rready", 64'(s_if.rready), 64'(0));
        check("t5_rst_arvalid", 64'(s_if.arvalid), 64'(0));
        check("t5_rst_last_err", 64'(last_err), 64'(0));
`ifdef ARB_PERF_EN
        check("t5_perf_g0", 64'(perf_grant0), 64'(0));
`endif
        rst = 1'b0;
        s_if.rvalid = 1'b0;
        s_if.rid    = '0;
        s_if.rdata  = '0;
        set_ar(0, 1'b1, 32'h8000_0400, 4'd1, 8'd0);
        set_ar(1, 1'b1, 32'h8000_0500, 4'd2, 8'd0);
        slave_read(1, 32'hE000_0000, who);
        check("t5_m0_first", 64'(who), 64'(0));
        slave_read(1, 32'hE000_0010, who);
        check("t5_m1_second", 64'(who), 64'(1));

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
